// File: rtl/dino_pkg.sv
// Shared state encoding and playfield geometry for the dino runner.
// Imported by the game engine and by the VGA renderer.
package dino_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    RISE = 3'd2,
    FALL = 3'd3,
    DEAD = 3'd4
  } state_t;

  localparam logic [9:0] FLOOR_Y   = 10'd360;
  localparam logic [9:0] FLOOR_BOT = 10'd380;
  localparam logic [9:0] CEILING   = 10'd100;

  function automatic logic [7:0] sat_inc(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// 2-flop synchroniser with a one-cycle edge strobe.
// Ports: clk_i, rst_ni, d_i (async in), edge_o (rise if RISE=1, else fall).
module sync_edge #(
  parameter bit RISE    = 1'b1,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic edge_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign edge_o = RISE ? (sync_q & ~prev_q)
                       : (~sync_q & prev_q);

endmodule

// File: rtl/dino_game_engine.sv
// Per-frame dino runner state: FSM, dino/cactus boxes, collision, score.
// Ports: CLK_25, RST_N, vga_vs, jump_n in; box edges, score, game_over, frame_tick out.
module dino_game_engine
  import dino_pkg::*;
#(
  parameter logic [9:0] D_LEFT     = 10'd60,
  parameter logic [9:0] DINO_W     = 10'd30,
  parameter logic [9:0] DINO_H     = 10'd60,
  parameter logic [9:0] JUMP_SPEED = 10'd10,
  parameter logic [9:0] CACTUS_W   = 10'd15,
  parameter logic [9:0] CACTUS_TOP = 10'd200,
  parameter logic [9:0] S_START    = 10'd600,
  parameter logic [9:0] S_SPEED    = 10'd5,
  parameter bit         COLL_EN    = 1'b1
) (
  input  logic       CLK_25,
  input  logic       RST_N,
  input  logic       vga_vs,
  input  logic       jump_n,
  output logic [9:0] d_up,
  output logic [9:0] d_down,
  output logic [9:0] d_left,
  output logic [9:0] d_right,
  output logic [9:0] s_up,
  output logic [9:0] s_down,
  output logic [9:0] s_left,
  output logic [9:0] s_right,
  output logic [7:0] score,
  output logic       game_over,
  output logic       frame_tick
);

  localparam logic [9:0] REST_UP = FLOOR_Y - DINO_H;
  localparam logic [9:0] D_RIGHT = D_LEFT + DINO_W;

  logic       vs_rise;
  logic       key_fall;
  logic       tick_q;
  logic       pend_q;
  state_t     state_q, state_d;
  logic [9:0] up_q, up_d;
  logic [9:0] dn_q;
  logic [9:0] sl_q, sl_d;
  logic [9:0] sr_q;
  logic [7:0] score_q, score_d;
  logic [9:0] sl_mv;
  logic [7:0] sc_mv;
  logic       hit;
  logic       live;

  sync_edge #(.RISE(1'b1), .RST_VAL(1'b0)) u_vs (
    .clk_i  (CLK_25),
    .rst_ni (RST_N),
    .d_i    (vga_vs),
    .edge_o (vs_rise)
  );

  sync_edge #(.RISE(1'b0), .RST_VAL(1'b1)) u_key (
    .clk_i  (CLK_25),
    .rst_ni (RST_N),
    .d_i    (jump_n),
    .edge_o (key_fall)
  );

  always_comb begin
    sl_mv = sl_q - S_SPEED;
    sc_mv = score_q;
    if (sl_q < S_SPEED) begin
      sl_mv = S_START;
      sc_mv = sat_inc(score_q);
    end
  end

  always_comb begin
    state_d = state_q;
    up_d    = up_q;
    sl_d    = sl_q;
    score_d = score_q;
    live    = 1'b0;
    hit     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d = RUN;
          score_d = 8'd0;
        end
      end
      RUN: begin
        live    = 1'b1;
        sl_d    = sl_mv;
        score_d = sc_mv;
        if (pend_q) state_d = RISE;
      end
      RISE: begin
        live    = 1'b1;
        sl_d    = sl_mv;
        score_d = sc_mv;
        // compare before subtracting so d_up never wraps
        if (up_q <= CEILING + JUMP_SPEED) begin
          up_d    = CEILING;
          state_d = FALL;
        end else begin
          up_d = up_q - JUMP_SPEED;
        end
      end
      FALL: begin
        live    = 1'b1;
        sl_d    = sl_mv;
        score_d = sc_mv;
        if (up_q + JUMP_SPEED + DINO_H >= FLOOR_Y) begin
          up_d    = REST_UP;
          state_d = RUN;
        end else begin
          up_d = up_q + JUMP_SPEED;
        end
      end
      DEAD: begin
        if (pend_q) begin
          state_d = IDLE;
          up_d    = REST_UP;
          sl_d    = S_START;
        end
      end
      default: state_d = IDLE;
    endcase
    hit = (D_RIGHT >= sl_d) &&
          (D_LEFT <= sl_d + CACTUS_W) &&
          (up_d + DINO_H > CACTUS_TOP);
    if (COLL_EN && live && hit) state_d = DEAD;
  end

  always_ff @(posedge CLK_25 or negedge RST_N) begin
    if (!RST_N) begin
      tick_q  <= 1'b0;
      pend_q  <= 1'b0;
      state_q <= IDLE;
      up_q    <= REST_UP;
      dn_q    <= FLOOR_Y;
      sl_q    <= S_START;
      sr_q    <= S_START + CACTUS_W;
      score_q <= 8'd0;
    end else begin
      tick_q <= vs_rise;
      // a tick consumes the old press; a same-cycle edge survives
      if (tick_q) pend_q <= key_fall;
      else if (key_fall) pend_q <= 1'b1;
      if (tick_q) begin
        state_q <= state_d;
        up_q    <= up_d;
        dn_q    <= up_d + DINO_H;
        sl_q    <= sl_d;
        sr_q    <= sl_d + CACTUS_W;
        score_q <= score_d;
      end
    end
  end

  assign d_up       = up_q;
  assign d_down     = dn_q;
  assign d_left     = D_LEFT;
  assign d_right    = D_RIGHT;
  assign s_up       = CACTUS_TOP;
  assign s_down     = FLOOR_Y;
  assign s_left     = sl_q;
  assign s_right    = sr_q;
  assign score      = score_q;
  assign game_over  = (state_q == DEAD);
  assign frame_tick = tick_q;

endmodule
